// File: rtl/pet_pkg.sv
// Shared types and counter-width helpers for the pet need bank.
package pet_pkg;

   typedef enum logic {OK = 1'b0, CRIT = 1'b1} channel_state_t;
   typedef enum logic {ALIVE = 1'b0, DEAD = 1'b1} life_state_t;

   localparam int CLK_HZ_DEF      = 50_000_000;
   localparam int DECAY_SEC_DEF   = 30;
   localparam int PENALTY_SEC_DEF = 20;

   localparam int PRESC_W = $clog2(CLK_HZ_DEF);
   localparam int DECAY_W = $clog2(DECAY_SEC_DEF);
   localparam int PEN_W   = $clog2(PENALTY_SEC_DEF);

   // Width of a counter spanning 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pet_need_channel.sv
// One need meter: care-edge detect, decay timer, penalty timer, OK/CRIT FSM.
//   state | meaning
//   OK    | value above the critical band, no penalty accrues
//   CRIT  | value <= CRIT_LVL, penalty timer runs on each second tick
module pet_need_channel
   import pet_pkg::*;
#(
   parameter int VAL_W       = 3,
   parameter int VAL_MAX     = 5,
   parameter int CRIT_LVL    = 2,
   parameter int DECAY_SEC   = 30,
   parameter int PENALTY_SEC = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             tick_i,
   input  logic             care_req_i,
   output logic [VAL_W-1:0] value_o,
   output logic             critical_o,
   output logic             penalty_o
);

   localparam int DW = cnt_w(DECAY_SEC);
   localparam int PW = cnt_w(PENALTY_SEC);
   localparam logic [DW-1:0]    DECAY_LAST = DW'(DECAY_SEC - 1);
   localparam logic [PW-1:0]    PEN_LAST   = PW'(PENALTY_SEC - 1);
   localparam logic [VAL_W-1:0] MAX_V      = VAL_W'(VAL_MAX);
   localparam logic [VAL_W-1:0] CRIT_V     = VAL_W'(CRIT_LVL);

   channel_state_t   state_q, state_d;
   logic [VAL_W-1:0] value_q, value_d;
   logic [DW-1:0]    decay_q, decay_d;
   logic [PW-1:0]    pen_q, pen_d;
   logic             care_q;
   logic             care_edge;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= OK;
         value_q <= MAX_V;
         decay_q <= '0;
         pen_q   <= '0;
         care_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         decay_q <= decay_d;
         pen_q   <= pen_d;
         care_q  <= care_req_i;
      end
   end

   always_comb begin
      care_edge = care_req_i & ~care_q & en_i;
      value_d   = value_q;
      decay_d   = decay_q;
      state_d   = state_q;
      pen_d     = pen_q;
      penalty_o = 1'b0;

      // A care edge beats a simultaneous decay wrap: restart the timer, no decrement.
      if (care_edge) begin
         decay_d = '0;
         if (value_q != MAX_V) value_d = value_q + 1'b1;
      end else if (en_i && tick_i) begin
         if (decay_q == DECAY_LAST) begin
            decay_d = '0;
            if (value_q != '0) value_d = value_q - 1'b1;
         end else begin
            decay_d = decay_q + 1'b1;
         end
      end

      if (en_i) begin
         case (state_q)
            OK:      if (value_q <= CRIT_V) state_d = CRIT;
            CRIT:    if (value_q >  CRIT_V) state_d = OK;
            default: state_d = OK;
         endcase
      end

      if (state_d != state_q) begin
         pen_d = '0;
      end else if (en_i && tick_i && state_q == CRIT) begin
         if (pen_q == PEN_LAST) begin
            pen_d     = '0;
            penalty_o = 1'b1;
         end else begin
            pen_d = pen_q + 1'b1;
         end
      end
   end

   assign value_o    = value_q;
   assign critical_o = (state_q == CRIT);

endmodule

// File: rtl/pet_need_bank.sv
// Bank of need channels sharing a one-second prescaler, a health meter and a life FSM.
//   state | meaning
//   ALIVE | needs decay and respond to care, health tracks penalties/heals
//   DEAD  | outputs held at zero, requests ignored until reset
module pet_need_bank
   import pet_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int N_NEEDS     = 4,
   parameter int VAL_W       = 3,
   parameter int VAL_MAX     = 5,
   parameter int CRIT_LVL    = 2,
   parameter int DECAY_SEC   = 30,
   parameter int PENALTY_SEC = 20
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_NEEDS-1:0]       care_req,
   input  logic                     heal_req,
   output logic [N_NEEDS*VAL_W-1:0] need_val,
   output logic [VAL_W-1:0]         health_val,
   output logic [N_NEEDS-1:0]       critical,
   output logic                     dead,
   output logic                     sec_tick
);

   localparam int SW = cnt_w(CLK_HZ);
   localparam logic [SW-1:0]    PRESC_LAST = SW'(CLK_HZ - 1);
   localparam logic [VAL_W-1:0] MAX_V      = VAL_W'(VAL_MAX);

   life_state_t          life_q, life_d;
   logic [SW-1:0]        presc_q, presc_d;
   logic                 tick_q, tick_d;
   logic [VAL_W-1:0]     health_q, health_d;
   logic                 heal_q;
   logic                 heal_edge, pen_any, alive;
   logic [N_NEEDS*VAL_W-1:0] need_raw;
   logic [N_NEEDS-1:0]   crit_vec, pen_vec;

   assign alive = (life_q == ALIVE);

   for (genvar g = 0; g < N_NEEDS; g++) begin : g_chan
      pet_need_channel #(
         .VAL_W       (VAL_W),
         .VAL_MAX     (VAL_MAX),
         .CRIT_LVL    (CRIT_LVL),
         .DECAY_SEC   (DECAY_SEC),
         .PENALTY_SEC (PENALTY_SEC)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .en_i       (alive),
         .tick_i     (tick_q),
         .care_req_i (care_req[g]),
         .value_o    (need_raw[g*VAL_W +: VAL_W]),
         .critical_o (crit_vec[g]),
         .penalty_o  (pen_vec[g])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         life_q   <= ALIVE;
         presc_q  <= '0;
         tick_q   <= 1'b0;
         health_q <= MAX_V;
         heal_q   <= 1'b0;
      end else begin
         life_q   <= life_d;
         presc_q  <= presc_d;
         tick_q   <= tick_d;
         health_q <= health_d;
         heal_q   <= heal_req;
      end
   end

   always_comb begin
      presc_d   = presc_q + 1'b1;
      tick_d    = 1'b0;
      health_d  = health_q;
      life_d    = life_q;
      heal_edge = heal_req & ~heal_q & alive;
      pen_any   = |pen_vec;

      if (presc_q == PRESC_LAST) begin
         presc_d = '0;
         tick_d  = 1'b1;
      end

      // Several channels penalising together still cost one point; a heal cancels it.
      if (pen_any && !heal_edge) begin
         if (health_q != '0) health_d = health_q - 1'b1;
      end else if (heal_edge && !pen_any) begin
         if (health_q != MAX_V) health_d = health_q + 1'b1;
      end

      case (life_q)
         ALIVE:   if (health_q == '0) life_d = DEAD;
         DEAD:    life_d = DEAD;
         default: life_d = ALIVE;
      endcase
   end

   assign need_val   = alive ? need_raw : '0;
   assign health_val = alive ? health_q : '0;
   assign critical   = alive ? crit_vec : '0;
   assign dead       = ~alive;
   assign sec_tick   = tick_q;

endmodule

// File: tb/tb_pet_need_bank.sv
// Directed bench for pet_need_bank with CLK_HZ=4, DECAY_SEC=3, PENALTY_SEC=2.
// edge_n counts rising edges after reset release; checks sample 1 time unit after an edge.
module tb_pet_need_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  care_req;
   logic        heal_req;
   logic [11:0] need_val;
   logic [2:0]  health_val;
   logic [3:0]  critical;
   logic        dead, sec_tick;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = 0;

   always #5 clk = ~clk;

   pet_need_bank #(
      .CLK_HZ(4), .N_NEEDS(4), .VAL_W(3), .VAL_MAX(5),
      .CRIT_LVL(2), .DECAY_SEC(3), .PENALTY_SEC(2)
   ) dut (
      .clk(clk), .rst(rst), .care_req(care_req), .heal_req(heal_req),
      .need_val(need_val), .health_val(health_val), .critical(critical),
      .dead(dead), .sec_tick(sec_tick)
   );

   function automatic logic [11:0] nv(input logic [2:0] v3, v2, v1, v0);
      return {v3, v2, v1, v0};
   endfunction

   task automatic adv_to(input int target);
      while (edge_n < target) begin
         @(posedge clk);
         #1;
         edge_n++;
      end
   endtask

   task automatic release_rst();
      @(posedge clk);
      #1 rst = 1'b1;
      edge_n = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; care_req = '0; heal_req = 1'b0;
      #2 rst = 1'b0;
      #10;
      n_checks++; if (need_val !== 12'hB6D) begin n_fail++; $display("FAIL rst_need got %h exp %h", need_val, 12'hB6D); end
      n_checks++; if (health_val !== 3'd5) begin n_fail++; $display("FAIL rst_health got %0d exp 5", health_val); end
      n_checks++; if (critical !== 4'h0) begin n_fail++; $display("FAIL rst_crit got %h exp 0", critical); end
      n_checks++; if (dead !== 1'b0) begin n_fail++; $display("FAIL rst_dead got %b exp 0", dead); end
      n_checks++; if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick got %b exp 0", sec_tick); end
      release_rst();
   endtask

   task automatic test_decay();
      adv_to(3);
      n_checks++; if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL tick_e3 got %b exp 0", sec_tick); end
      adv_to(4);
      n_checks++; if (sec_tick !== 1'b1) begin n_fail++; $display("FAIL tick_e4 got %b exp 1", sec_tick); end
      adv_to(5);
      n_checks++; if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL tick_e5 got %b exp 0", sec_tick); end
      adv_to(12);
      n_checks++; if (need_val !== nv(5,5,5,5)) begin n_fail++; $display("FAIL decay_e12 got %h exp %h", need_val, nv(5,5,5,5)); end
      adv_to(13);
      n_checks++; if (need_val !== nv(4,4,4,4)) begin n_fail++; $display("FAIL decay_e13 got %h exp %h", need_val, nv(4,4,4,4)); end
      adv_to(25);
      n_checks++; if (need_val !== nv(3,3,3,3)) begin n_fail++; $display("FAIL decay_e25 got %h exp %h", need_val, nv(3,3,3,3)); end
      adv_to(37);
      n_checks++; if (need_val !== nv(2,2,2,2)) begin n_fail++; $display("FAIL decay_e37 got %h exp %h", need_val, nv(2,2,2,2)); end
      n_checks++; if (critical !== 4'h0) begin n_fail++; $display("FAIL crit_lag_e37 got %h exp 0", critical); end
      adv_to(38);
      n_checks++; if (critical !== 4'hF) begin n_fail++; $display("FAIL crit_e38 got %h exp f", critical); end
      n_checks++; if (health_val !== 3'd5) begin n_fail++; $display("FAIL health_e38 got %0d exp 5", health_val); end
   endtask

   task automatic test_penalty_heal();
      adv_to(44);
      n_checks++; if (health_val !== 3'd5) begin n_fail++; $display("FAIL pen_e44 got %0d exp 5", health_val); end
      adv_to(45);
      n_checks++; if (health_val !== 3'd4) begin n_fail++; $display("FAIL pen_or_e45 got %0d exp 4", health_val); end
      adv_to(52); heal_req = 1'b1;
      adv_to(53);
      n_checks++; if (health_val !== 3'd4) begin n_fail++; $display("FAIL heal_vs_pen_e53 got %0d exp 4", health_val); end
      heal_req = 1'b0;
      adv_to(55); heal_req = 1'b1;
      adv_to(56);
      n_checks++; if (health_val !== 3'd5) begin n_fail++; $display("FAIL heal_e56 got %0d exp 5", health_val); end
      heal_req = 1'b0;
      adv_to(61);
      n_checks++; if (need_val !== nv(0,0,0,0)) begin n_fail++; $display("FAIL floor_e61 got %h exp 0", need_val); end
      n_checks++; if (health_val !== 3'd4) begin n_fail++; $display("FAIL pen_e61 got %0d exp 4", health_val); end
   endtask

   task automatic test_death();
      adv_to(89); care_req = 4'b0001;
      adv_to(90);
      n_checks++; if (need_val !== nv(0,0,0,1)) begin n_fail++; $display("FAIL care_e90 got %h exp %h", need_val, nv(0,0,0,1)); end
      n_checks++; if (health_val !== 3'd1) begin n_fail++; $display("FAIL health_e90 got %0d exp 1", health_val); end
      care_req = '0;
      adv_to(93);
      n_checks++; if (health_val !== 3'd0) begin n_fail++; $display("FAIL health_e93 got %0d exp 0", health_val); end
      n_checks++; if (dead !== 1'b0) begin n_fail++; $display("FAIL dead_lag_e93 got %b exp 0", dead); end
      adv_to(94);
      n_checks++; if (dead !== 1'b1) begin n_fail++; $display("FAIL dead_e94 got %b exp 1", dead); end
      n_checks++; if (need_val !== 12'h000) begin n_fail++; $display("FAIL dead_need_e94 got %h exp 0", need_val); end
      n_checks++; if (critical !== 4'h0) begin n_fail++; $display("FAIL dead_crit_e94 got %h exp 0", critical); end
      adv_to(96);
      n_checks++; if (sec_tick !== 1'b1) begin n_fail++; $display("FAIL dead_tick_e96 got %b exp 1", sec_tick); end
      for (int i = 0; i < 10; i++) begin
         care_req = 4'hF; heal_req = 1'b1;
         adv_to(edge_n + 5);
         care_req = '0; heal_req = 1'b0;
         adv_to(edge_n + 5);
         n_checks++; if (need_val !== 12'h000) begin n_fail++; $display("FAIL dead_ignore_need[%0d] got %h exp 0", i, need_val); end
         n_checks++; if (health_val !== 3'd0) begin n_fail++; $display("FAIL dead_ignore_health[%0d] got %0d exp 0", i, health_val); end
         n_checks++; if (dead !== 1'b1) begin n_fail++; $display("FAIL dead_hold[%0d] got %b exp 1", i, dead); end
      end
   endtask

   task automatic test_reset_mid_second();
      adv_to(198);
      rst = 1'b0;
      #1;
      n_checks++; if (need_val !== 12'hB6D) begin n_fail++; $display("FAIL mid_rst_need got %h exp %h", need_val, 12'hB6D); end
      n_checks++; if (health_val !== 3'd5) begin n_fail++; $display("FAIL mid_rst_health got %0d exp 5", health_val); end
      n_checks++; if (dead !== 1'b0) begin n_fail++; $display("FAIL mid_rst_dead got %b exp 0", dead); end
      @(posedge clk);
      release_rst();
      adv_to(3);
      n_checks++; if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL mid_tick_e3 got %b exp 0", sec_tick); end
      adv_to(4);
      n_checks++; if (sec_tick !== 1'b1) begin n_fail++; $display("FAIL mid_tick_e4 got %b exp 1", sec_tick); end
   endtask

   task automatic test_care();
      adv_to(13);
      n_checks++; if (need_val !== nv(4,4,4,4)) begin n_fail++; $display("FAIL care_pre_e13 got %h exp %h", need_val, nv(4,4,4,4)); end
      adv_to(16); care_req = 4'b0010;
      adv_to(17);
      n_checks++; if (need_val !== nv(4,4,5,4)) begin n_fail++; $display("FAIL care_e17 got %h exp %h", need_val, nv(4,4,5,4)); end
      adv_to(26);
      n_checks++; if (need_val !== nv(3,3,5,3)) begin n_fail++; $display("FAIL care_hold_e26 got %h exp %h", need_val, nv(3,3,5,3)); end
      care_req = '0;
      adv_to(27); care_req = 4'b0010;
      adv_to(28);
      n_checks++; if (need_val !== nv(3,3,5,3)) begin n_fail++; $display("FAIL care_sat_e28 got %h exp %h", need_val, nv(3,3,5,3)); end
      care_req = '0;
      adv_to(29);
      n_checks++; if (need_val !== nv(3,3,5,3)) begin n_fail++; $display("FAIL decay_restart_e29 got %h exp %h", need_val, nv(3,3,5,3)); end
      adv_to(36); care_req = 4'b0001;
      adv_to(37);
      n_checks++; if (need_val !== nv(2,2,4,4)) begin n_fail++; $display("FAIL care_vs_wrap_e37 got %h exp %h", need_val, nv(2,2,4,4)); end
      care_req = '0;
      adv_to(38);
      n_checks++; if (critical !== 4'b1100) begin n_fail++; $display("FAIL crit_e38b got %h exp c", critical); end
      care_req = 4'b1000;
      adv_to(39);
      n_checks++; if (need_val !== nv(3,2,4,4)) begin n_fail++; $display("FAIL care_crit_e39 got %h exp %h", need_val, nv(3,2,4,4)); end
      adv_to(40);
      n_checks++; if (critical !== 4'b0100) begin n_fail++; $display("FAIL crit_exit_e40 got %h exp 4", critical); end
      adv_to(48);
      n_checks++; if (need_val !== nv(3,2,4,4)) begin n_fail++; $display("FAIL care_once_e48 got %h exp %h", need_val, nv(3,2,4,4)); end
      n_checks++; if (health_val !== 3'd4) begin n_fail++; $display("FAIL one_chan_pen_e48 got %0d exp 4", health_val); end
      care_req = '0;
   endtask

   initial begin
      test_reset();
      test_decay();
      test_penalty_heal();
      test_death();
      test_reset_mid_second();
      test_care();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
